// File: rtl/regfile_pkg.sv
// regfile_pkg: shared definitions for register_file_multilane.
//   ptr_op_e : pointer-pair operation encodings
//   lane_lo  : low bit index of lane k within a packed per-lane bus
package regfile_pkg;

  typedef enum logic [1:0] {
    PTR_NONE = 2'b00,
    PTR_INC  = 2'b01,
    PTR_DEC  = 2'b10,
    PTR_RSVD = 2'b11
  } ptr_op_e;

  function automatic int unsigned lane_lo(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

endpackage

// File: rtl/regfile_ptr_unit.sv
// regfile_ptr_unit: pointer-pair engine for register_file_multilane.
// Takes the current pair value {reg[sel+1], reg[sel]} and produces the
// post-increment / pre-decrement result for the array, plus the registered
// effective-address outputs.
//   clock, nreset : falling-edge clock, async active-low reset
//   ptr_op        : 00 none, 01 post-inc, 10 pre-dec, 11 treated as none
//   ptr_sel       : low register of the pair; odd values are rejected
//   pair_q        : current pair value fetched by the top
//   upd_en        : pair is to be written with upd_val this edge
//   upd_val       : new pair value (modulo 2**(2*DATA_W))
//   ptr_out       : registered effective address (holds when no valid op)
//   ptr_valid     : 1-cycle pulse, ptr_out updated
//   ptr_err       : 1-cycle pulse, odd ptr_sel, op dropped
module regfile_ptr_unit
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 5
) (
  input  logic                  clock,
  input  logic                  nreset,
  input  logic [1:0]            ptr_op,
  input  logic [ADDR_W-1:0]     ptr_sel,
  input  logic [2*DATA_W-1:0]   pair_q,
  output logic                  upd_en,
  output logic [2*DATA_W-1:0]   upd_val,
  output logic [2*DATA_W-1:0]   ptr_out,
  output logic                  ptr_valid,
  output logic                  ptr_err
);

  localparam logic [2*DATA_W-1:0] ONE = {{(2*DATA_W-1){1'b0}}, 1'b1};

  ptr_op_e op;
  logic    is_inc;
  logic    is_dec;
  logic    active;

  always_comb begin
    op      = ptr_op_e'(ptr_op);
    is_inc  = (op == PTR_INC);
    is_dec  = (op == PTR_DEC);
    active  = is_inc | is_dec;
    upd_en  = active & ~ptr_sel[0];
    upd_val = is_inc ? (pair_q + ONE) : (pair_q - ONE);
  end

  always_ff @(negedge clock or negedge nreset) begin
    if (!nreset) begin
      ptr_out   <= '0;
      ptr_valid <= 1'b0;
      ptr_err   <= 1'b0;
    end else begin
      ptr_valid <= upd_en;
      ptr_err   <= active & ptr_sel[0];
      // post-inc reports the old pair, pre-dec reports the new one
      if (upd_en) ptr_out <= is_inc ? pair_q : upd_val;
    end
  end

endmodule

// File: rtl/register_file_multilane.sv
// register_file_multilane: NUM_REGS x DATA_W register file with LANES
// independent write/read lanes (registered reads) and a pointer-pair unit.
// All state changes on the falling edge of clock; nreset is async active-low.
//   wr_en/wr_addr/data_in : per-lane writes, highest lane wins on same address
//   rd_en/rd_addr         : per-lane reads; data_out is 0 for disabled lanes
//   ptr_op/ptr_sel        : pair post-inc / pre-dec on {reg[sel+1], reg[sel]}
//   ptr_out/ptr_valid/ptr_err : pointer results (see regfile_ptr_unit)
// Optional macro REGFILE_BYPASS_EN: reads return the value written on the
// same edge; otherwise reads return the pre-write value.
module register_file_multilane
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned LANES    = 2,
  parameter int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                      clock,
  input  logic                      nreset,
  input  logic [LANES-1:0]          wr_en,
  input  logic [LANES*ADDR_W-1:0]   wr_addr,
  input  logic [LANES*DATA_W-1:0]   data_in,
  input  logic [LANES-1:0]          rd_en,
  input  logic [LANES*ADDR_W-1:0]   rd_addr,
  output logic [LANES*DATA_W-1:0]   data_out,
  input  logic [1:0]                ptr_op,
  input  logic [ADDR_W-1:0]         ptr_sel,
  output logic [2*DATA_W-1:0]       ptr_out,
  output logic                      ptr_valid,
  output logic                      ptr_err
);

  logic [DATA_W-1:0]   regs      [NUM_REGS];
  logic [DATA_W-1:0]   regs_next [NUM_REGS];
  logic [ADDR_W-1:0]   sel_hi;
  logic [2*DATA_W-1:0] pair_q;
  logic                upd_en;
  logic [2*DATA_W-1:0] upd_val;

  assign sel_hi = {ptr_sel[ADDR_W-1:1], 1'b1};
  assign pair_q = {regs[sel_hi], regs[ptr_sel]};

  regfile_ptr_unit #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ptr (
    .clock     (clock),
    .nreset    (nreset),
    .ptr_op    (ptr_op),
    .ptr_sel   (ptr_sel),
    .pair_q    (pair_q),
    .upd_en    (upd_en),
    .upd_val   (upd_val),
    .ptr_out   (ptr_out),
    .ptr_valid (ptr_valid),
    .ptr_err   (ptr_err)
  );

  // Pointer update applied first, then lanes in ascending order, so a lane
  // write overrides only the byte it hits and the highest lane wins.
  always_comb begin
    regs_next = regs;
    if (upd_en) begin
      regs_next[ptr_sel] = upd_val[DATA_W-1:0];
      regs_next[sel_hi]  = upd_val[2*DATA_W-1:DATA_W];
    end
    for (int unsigned k = 0; k < LANES; k++) begin
      if (wr_en[k])
        regs_next[wr_addr[lane_lo(k, ADDR_W) +: ADDR_W]] = data_in[lane_lo(k, DATA_W) +: DATA_W];
    end
  end

  always_ff @(negedge clock or negedge nreset) begin
    if (!nreset) begin
      regs <= '{default: '0};
    end else begin
      regs <= regs_next;
    end
  end

  always_ff @(negedge clock or negedge nreset) begin
    if (!nreset) begin
      data_out <= '0;
    end else begin
      for (int unsigned k = 0; k < LANES; k++) begin
        if (rd_en[k])
`ifdef REGFILE_BYPASS_EN
          data_out[lane_lo(k, DATA_W) +: DATA_W] <= regs_next[rd_addr[lane_lo(k, ADDR_W) +: ADDR_W]];
`else
          data_out[lane_lo(k, DATA_W) +: DATA_W] <= regs[rd_addr[lane_lo(k, ADDR_W) +: ADDR_W]];
`endif
        else
          data_out[lane_lo(k, DATA_W) +: DATA_W] <= '0;
      end
    end
  end

endmodule
